// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the RV32I load/store controller.
//               Load/store type codes, FSM state encoding, and helpers that
//               decode the access size and check whether a type is legal.
// Revision    : 1.0  initial release
// ============================================================================
package lsu_pkg;

    // Access type codes. Stores reuse the low three codes (SB/SH/SW).
    localparam logic [2:0] c_T_B  = 3'b000;
    localparam logic [2:0] c_T_H  = 3'b001;
    localparam logic [2:0] c_T_W  = 3'b010;
    localparam logic [2:0] c_T_BU = 3'b011;
    localparam logic [2:0] c_T_HU = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // Access size in bytes (1, 2 or 4). Illegal codes decode to 1 so that the
    // misalignment logic stays well defined; they never reach memory anyway.
    function automatic logic [2:0] lsu_size(input logic [2:0] t);
        case (t)
            c_T_H, c_T_HU: lsu_size = 3'd2;
            c_T_W:         lsu_size = 3'd4;
            default:       lsu_size = 3'd1;
        endcase
    endfunction

    function automatic logic lsu_type_ok(input logic we, input logic [2:0] t);
        lsu_type_ok = we ? (t <= c_T_W) : (t <= c_T_HU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align_extend.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align_extend
// Description : Combinational load-data aligner. Selects the 32-bit window
//               starting at byte offset `offset` of the 64-bit buffer
//               {hi, lo} and sign/zero extends it according to the load type.
// Ports       : buf_data [63:0] in  - captured words {hi, lo}
//               offset   [1:0]  in  - byte offset of the access
//               ld_type  [2:0]  in  - load type code
//               rdata    [31:0] out - aligned, extended load data
// Revision    : 1.0  initial release
// ============================================================================
module lsu_align_extend
    import lsu_pkg::*;
(
    input  logic [63:0] buf_data,
    input  logic [1:0]  offset,
    input  logic [2:0]  ld_type,
    output logic [31:0] rdata
);

    logic [31:0] w_word;

    // Equivalent to ({hi,lo} >> 8*offset)[31:0].
    assign w_word = buf_data[{offset, 3'b000} +: 32];

    always_comb begin
        rdata = w_word;
        case (ld_type)
            c_T_B:   rdata = {{24{w_word[7]}},  w_word[7:0]};
            c_T_H:   rdata = {{16{w_word[15]}}, w_word[15:0]};
            c_T_BU:  rdata = {24'b0, w_word[7:0]};
            c_T_HU:  rdata = {16'b0, w_word[15:0]};
            default: rdata = w_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl_rv32i.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ctrl_rv32i
// Description : Load/store sequencer between the core memory stage and a
//               multi-cycle word-addressed data memory (req/ack handshake).
//               One request at a time; misaligned accesses are split into two
//               word transactions; a per-transaction timeout guards against a
//               hung memory.
// Ports       : clk, rst_n                      - clock, async active-low reset
//               req_valid/req_ready/req_we/req_type/req_addr/req_wdata
//                                               - core request
//               rsp_valid/rsp_rdata/rsp_err     - one-cycle registered response
//               mem_req/mem_we/mem_addr/mem_be/mem_wdata/mem_ack/mem_rdata
//                                               - data memory port
// Revision    : 1.0  initial release
// ============================================================================
module lsu_ctrl_rv32i
    import lsu_pkg::*;
#(
    parameter int TIMEOUT  = 16,
    parameter int SPLIT_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int              c_CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_CW-1:0] c_TMAX = c_CW'(TIMEOUT - 1);

    lsu_state_t r_state, w_state_nxt;

    logic            r_we;
    logic [2:0]      r_type;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic            r_split;
    logic            r_err;
    logic [31:0]     r_lo, r_hi;
    logic [c_CW-1:0] r_cnt;
    logic            r_rsp_valid;
    logic            r_rsp_err;
    logic [31:0]     r_rsp_rdata;

    logic            w_accept;
    logic [2:0]      w_req_size;
    logic            w_req_mis;
    logic            w_req_bad;
    logic            w_timeout;
    logic [2:0]      w_size;
    logic [7:0]      w_mask8;
    logic [7:0]      w_be8;
    logic [63:0]     w_wd64;
    logic [31:0]     w_word_addr;
    logic [31:0]     w_ext;

    // Request decode, evaluated on the incoming request while in IDLE.
    assign w_accept   = req_valid && (r_state == IDLE);
    assign w_req_size = lsu_size(req_type);
    assign w_req_mis  = ({2'b00, req_addr[1:0]} + {1'b0, w_req_size}) > 4'd4;
    assign w_req_bad  = !lsu_type_ok(req_we, req_type) || (w_req_mis && (SPLIT_EN == 0));

    // The counter restarts on every state change, so it counts cycles spent in
    // the current access. An ack on the last allowed cycle still wins.
    assign w_timeout  = (TIMEOUT != 0) && (r_cnt == c_TMAX) && !mem_ack;

    // Lanes and enables over a 64-bit span: low word for ACC0, high for ACC1.
    assign w_size      = lsu_size(r_type);
    assign w_mask8     = (w_size == 3'd4) ? 8'h0F : (w_size == 3'd2) ? 8'h03 : 8'h01;
    assign w_be8       = w_mask8 << r_addr[1:0];
    assign w_wd64      = {32'b0, r_wdata} << {r_addr[1:0], 3'b000};
    assign w_word_addr = {r_addr[31:2], 2'b00};

    lsu_align_extend u_align (
        .buf_data (({r_hi, r_lo})),
        .offset   (r_addr[1:0]),
        .ld_type  (r_type),
        .rdata    (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 32'b0;
        mem_be      = 4'b0;
        mem_wdata   = 32'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = w_req_bad ? RESP : ACC0;
            end
            ACC0: begin
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_addr  = w_word_addr;
                mem_be    = w_be8[3:0];
                mem_wdata = r_we ? w_wd64[31:0] : 32'b0;
                if (mem_ack)        w_state_nxt = r_split ? ACC1 : RESP;
                else if (w_timeout) w_state_nxt = RESP;
            end
            ACC1: begin
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_addr  = w_word_addr + 32'd4;
                mem_be    = w_be8[7:4];
                mem_wdata = r_we ? w_wd64[63:32] : 32'b0;
                if (mem_ack || w_timeout) w_state_nxt = RESP;
            end
            RESP: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_type      <= 3'b0;
            r_addr      <= 32'b0;
            r_wdata     <= 32'b0;
            r_split     <= 1'b0;
            r_err       <= 1'b0;
            r_lo        <= 32'b0;
            r_hi        <= 32'b0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_type  <= req_type;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_split <= w_req_mis;
                r_err   <= w_req_bad;
                r_lo    <= 32'b0;
                r_hi    <= 32'b0;
            end
            if (r_state == ACC0 && mem_ack) r_lo <= mem_rdata;
            if (r_state == ACC1 && mem_ack) r_hi <= mem_rdata;
            if ((r_state == ACC0 || r_state == ACC1) && w_timeout) r_err <= 1'b1;

            r_cnt <= (w_state_nxt != r_state) ? '0 : r_cnt + c_CW'(1);

            // Response is registered out of RESP: one-cycle pulse, no backpressure.
            r_rsp_valid <= (r_state == RESP);
            r_rsp_err   <= (r_state == RESP) && r_err;
            r_rsp_rdata <= (r_state == RESP && !r_err && !r_we) ? w_ext : 32'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl_rv32i.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ctrl_rv32i
// Description : Directed self-checking bench for lsu_ctrl_rv32i. Expected
//               memory transactions and responses are queued when a request
//               is driven and popped as the DUT produces them.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lsu_ctrl_rv32i;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_type;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mtx_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    mtx_t        exp_mem[$];
    rsp_t        exp_rsp[$];
    logic [31:0] mem_arr [0:255];

    lsu_ctrl_rv32i #(.TIMEOUT(16), .SPLIT_EN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_type  (req_type),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge; returns at the falling edge after
    // the accepting rising edge (cycle 1 relative to accept).
    task automatic drive_req(input logic we, input logic [2:0] t,
                             input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1;
        req_we    = we;
        req_type  = t;
        req_addr  = a;
        req_wdata = wd;
        check("req_ready_at_accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_type  = 3'b0;
        req_addr  = 32'b0;
        req_wdata = 32'b0;
    endtask

    // Memory responder plus response monitor. ack_dly < 0 never acks.
    task automatic service(input string tag, input int ack_dly,
                           input int exp_lat, input int exp_mreq);
        int   cyc      = 1;
        int   wcnt     = 0;
        int   mreq_cyc = 0;
        bit   done     = 0;
        mtx_t m;
        rsp_t r;
        while (!done && cyc < 60) begin
            mem_ack = 1'b0;
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    check({tag, "_rsp_unexpected"}, 32'd1, 32'd0);
                end else begin
                    r = exp_rsp.pop_front();
                    check({tag, "_rdata"}, rsp_rdata, r.rdata);
                    check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, r.err});
                end
                check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
                done = 1;
            end else begin
                if (mem_req) begin
                    mreq_cyc++;
                    if (wcnt == 0) begin
                        if (exp_mem.size() == 0) begin
                            check({tag, "_mem_unexpected"}, 32'd1, 32'd0);
                        end else begin
                            m = exp_mem.pop_front();
                            check({tag, "_mem_we"}, {31'b0, mem_we}, {31'b0, m.we});
                            check({tag, "_mem_addr"}, mem_addr, m.addr);
                            check({tag, "_mem_be"}, {28'b0, mem_be}, {28'b0, m.be});
                            if (m.we) check({tag, "_mem_wdata"}, mem_wdata, m.wdata);
                        end
                    end
                    if (wcnt == ack_dly) begin
                        mem_ack   = 1'b1;
                        mem_rdata = mem_arr[mem_addr[9:2]];
                        wcnt      = 0;
                    end else begin
                        wcnt++;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) check({tag, "_no_response"}, 32'd0, 32'd1);
        check({tag, "_mreq_cycles"}, 32'(mreq_cyc), 32'(exp_mreq));
        check({tag, "_mem_q_left"}, 32'(exp_mem.size()), 32'd0);
        @(negedge clk);
        check({tag, "_single_pulse"}, {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_type  = 3'b0;
        req_addr  = 32'b0;
        req_wdata = 32'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'b0;
        mem_arr[8'h40] = 32'h80123456;  // 0x100
        mem_arr[8'h41] = 32'h0BADF00D;  // 0x104
        mem_arr[8'h80] = 32'hAABBCCDD;  // 0x200
        mem_arr[8'h81] = 32'h11223344;  // 0x204
        mem_arr[8'hC0] = 32'hCAFEF00D;  // 0x300

        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_be", {28'b0, mem_be}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // LB at 0x103: sign-extended 0x80, minimum latency
        exp_mem.push_back('{1'b0, 32'h100, 4'b1000, 32'h0});
        exp_rsp.push_back('{32'hFFFFFF80, 1'b0});
        drive_req(1'b0, 3'b000, 32'h103, 32'h0);
        service("lb", 0, 3, 1);

        // Misaligned LHU at 0x203
        exp_mem.push_back('{1'b0, 32'h200, 4'b1000, 32'h0});
        exp_mem.push_back('{1'b0, 32'h204, 4'b0001, 32'h0});
        exp_rsp.push_back('{32'h000044AA, 1'b0});
        drive_req(1'b0, 3'b100, 32'h203, 32'h0);
        service("lhu_split", 0, 4, 2);

        // Misaligned SW at 0x102
        exp_mem.push_back('{1'b1, 32'h100, 4'b1100, 32'hBEEF0000});
        exp_mem.push_back('{1'b1, 32'h104, 4'b0011, 32'h0000DEAD});
        exp_rsp.push_back('{32'h0, 1'b0});
        drive_req(1'b1, 3'b010, 32'h102, 32'hDEADBEEF);
        service("sw_split", 0, 4, 2);

        // Invalid types: no memory access, error two cycles after accept
        exp_rsp.push_back('{32'h0, 1'b1});
        drive_req(1'b0, 3'b101, 32'h100, 32'h0);
        service("bad_load", 0, 2, 0);
        exp_rsp.push_back('{32'h0, 1'b1});
        drive_req(1'b1, 3'b011, 32'h100, 32'h1234);
        service("bad_store", 0, 2, 0);

        // Hung memory: timeout after 16 cycles of mem_req
        exp_mem.push_back('{1'b0, 32'h100, 4'b1111, 32'h0});
        exp_rsp.push_back('{32'h0, 1'b1});
        drive_req(1'b0, 3'b010, 32'h100, 32'h0);
        service("timeout", -1, 18, 16);

        // Next request after timeout, ack after 3 request cycles
        exp_mem.push_back('{1'b0, 32'h104, 4'b1111, 32'h0});
        exp_rsp.push_back('{32'h0BADF00D, 1'b0});
        drive_req(1'b0, 3'b010, 32'h104, 32'h0);
        service("lw_after_to", 2, 5, 3);

        // Ack on the last cycle before timeout still completes
        exp_mem.push_back('{1'b0, 32'h100, 4'b1111, 32'h0});
        exp_rsp.push_back('{32'h80123456, 1'b0});
        drive_req(1'b0, 3'b010, 32'h100, 32'h0);
        service("ack_at_limit", 15, 18, 16);

        // LH at offset 2 (fits in word), sign extension
        exp_mem.push_back('{1'b0, 32'h100, 4'b1100, 32'h0});
        exp_rsp.push_back('{32'hFFFF8012, 1'b0});
        drive_req(1'b0, 3'b001, 32'h102, 32'h0);
        service("lh", 0, 3, 1);

        // LBU at 0x103: zero extension
        exp_mem.push_back('{1'b0, 32'h100, 4'b1000, 32'h0});
        exp_rsp.push_back('{32'h00000080, 1'b0});
        drive_req(1'b0, 3'b011, 32'h103, 32'h0);
        service("lbu", 0, 3, 1);

        // SB at 0x101
        exp_mem.push_back('{1'b1, 32'h100, 4'b0010, 32'h0000A500});
        exp_rsp.push_back('{32'h0, 1'b0});
        drive_req(1'b1, 3'b000, 32'h101, 32'h000000A5);
        service("sb", 0, 3, 1);

        // Stray ack while idle is ignored
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("stray_ack_mem_req", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        check("stray_ack_rsp", {31'b0, rsp_valid}, 32'd0);
        check("stray_ack_ready", {31'b0, req_ready}, 32'd1);

        // Reset asserted during ACC1 of a split LH
        drive_req(1'b0, 3'b001, 32'h203, 32'h0);
        check("rst_mid_acc0_req", {31'b0, mem_req}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = mem_arr[8'h80];
        @(negedge clk);
        mem_ack = 1'b0;
        check("rst_mid_acc1_req", {31'b0, mem_req}, 32'd1);
        check("rst_mid_acc1_addr", mem_addr, 32'h204);
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        check("rst_mid_rsp0", {31'b0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_no_rsp", {31'b0, rsp_valid}, 32'd0);
        end

        // Normal LW after the reset
        exp_mem.push_back('{1'b0, 32'h300, 4'b1111, 32'h0});
        exp_rsp.push_back('{32'hCAFEF00D, 1'b0});
        drive_req(1'b0, 3'b010, 32'h300, 32'h0);
        service("lw_after_rst", 0, 3, 1);

        check("rsp_q_left", 32'(exp_rsp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
